// File: rtl/instr_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit words and writes them to RAM.
// Optional macro LOADER_CHECKSUM_EN appends an XOR checksum byte that must match the data bytes.
module instr_loader #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        core_rst_o
);

  localparam int CW = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM  = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [CW-1:0] word_cnt;
  logic [31:0]   asm_word;
  logic [31:0]   addr;
  logic [31:0]   shifted;
  logic          accept;
  state_t        end_state;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  // Bytes arrive LSB first, so each new byte enters at the top and slides down.
  assign shifted = {byte_data_i, asm_word[31:8]};
  assign accept  = byte_valid_i && byte_ready_o;

`ifdef LOADER_CHECKSUM_EN
  assign end_state = S_CSUM;
`else
  assign end_state = S_DONE;
`endif

  // Outputs are pure decodes of registered state, so they change only on clock or reset.
  always_comb begin
    byte_ready_o = (state == S_LEN) || (state == S_DATA);
    busy_o       = (state == S_LEN) || (state == S_DATA) || (state == S_WRITE);
`ifdef LOADER_CHECKSUM_EN
    byte_ready_o = byte_ready_o || (state == S_CSUM);
    busy_o       = busy_o || (state == S_CSUM);
`endif
  end

  assign mem_we_o    = (state == S_WRITE);
  assign mem_addr_o  = addr;
  assign mem_wdata_o = asm_word;
  assign done_o      = (state == S_DONE);
  assign error_o     = (state == S_ERR);
  assign core_rst_o  = (state != S_DONE);

  // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      byte_cnt <= '0;
      word_cnt <= '0;
      asm_word <= '0;
      addr     <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state    <= S_LEN;
            byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end

        S_LEN: begin
          if (accept) begin
            asm_word <= shifted;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (shifted == 32'd0) begin
                state <= end_state;
              end else if (shifted > 32'(DEPTH_WORDS)) begin
                state <= S_ERR;
              end else begin
                state    <= S_DATA;
                word_cnt <= shifted[CW-1:0];
                addr     <= BASE_ADDR;
              end
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            asm_word <= shifted;
            byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum ^ byte_data_i;
`endif
            if (byte_cnt == 2'd3) state <= S_WRITE;
          end
        end

        S_WRITE: begin
          word_cnt <= word_cnt - 1'b1;
          // Address stops at the last written word so it never passes the memory end.
          if (word_cnt == CW'(1)) begin
            state <= end_state;
          end else begin
            addr  <= addr + 32'd4;
            state <= S_DATA;
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) state <= (byte_data_i == csum) ? S_DONE : S_ERR;
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the instruction memory: receives a program image as a byte stream (e.g. from a UART receiver), assembles little-endian 32-bit words and issues one write per word into the instruction RAM.
- Holds the core in reset while loading and reports completion or error.
- Sits between the serial front end and the instruction memory write port.

Parameters:
- DEPTH_WORDS, 1024: capacity of the instruction memory in 32-bit words; longer images are rejected.
- BASE_ADDR, 32'h0000_0000: byte address of the first written word; must be 4-byte aligned.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- byte_data_i  input  8  incoming stream byte.
- byte_valid_i  input  1  byte_data_i is valid.
- byte_ready_o  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid_i and byte_ready_o are both high at a rising edge.
- mem_we_o  output  1  instruction RAM write enable, one-cycle pulse per word.
- mem_addr_o  output  32  byte address of the write.
- mem_wdata_o  output  32  word to write.
- busy_o  output  1  load in progress.
- done_o  output  1  last load completed successfully.
- error_o  output  1  last load aborted.
- core_rst_o  output  1  reset request to the CPU core.

Behaviour:
- Reset: state IDLE.
  - All outputs 0 except core_rst_o = 1.
  - mem_addr_o = BASE_ADDR; internal byte counter = 0; word counter = 0.
- Image format:
  - 4-byte length N (word count, LSB first).
  - Then N words, each LSB first: byte k of a word goes to bits [8k+7:8k].
- IDLE: byte_ready_o = 0. start_i moves to LEN and clears done_o and error_o.
- LEN:
  - byte_ready_o = 1; busy_o = 1.
  - After the 4th accepted byte:
    - N == 0 -> DONE with no writes.
    - N > DEPTH_WORDS -> ERR.
    - Otherwise -> DATA, with word counter = N and mem_addr_o = BASE_ADDR.
- DATA:
  - byte_ready_o = 1; bytes are shifted into the assembly register.
  - After the 4th byte -> WRITE; the byte counter wraps 3 -> 0.
- WRITE, exactly one cycle:
  - byte_ready_o = 0; mem_we_o = 1; mem_addr_o and mem_wdata_o are stable.
  - Next cycle: mem_addr_o += 4 and the word counter decrements.
  - Counter reaches 0 -> DONE; otherwise -> DATA.
- Throughput and latency:
  - One write cycle is inserted per word, so full-rate input gives 5 cycles per word.
  - The write pulse appears in the cycle after the word's 4th byte is accepted.
- DONE: done_o = 1 held; core_rst_o = 0; byte_ready_o = 0.
- ERR: error_o = 1 held; core_rst_o = 1; byte_ready_o = 0.
- start_i in DONE or ERR restarts at LEN. start_i is ignored in LEN, DATA and WRITE.
- busy_o = 1 in LEN, DATA and WRITE only.
- core_rst_o = 1 in every state except DONE.
- The address never exceeds BASE_ADDR + 4*(DEPTH_WORDS-1), guaranteed by the length check.
- byte_valid_i low stalls the load indefinitely with no timeout. State and partial word are retained.
- Reset asserted mid-load:
  - Aborts immediately to IDLE.
  - mem_we_o drops asynchronously.
  - The partial word is discarded and never written.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word, one extra byte is accepted in state CSUM (byte_ready_o = 1, busy_o = 1).
  - It must equal the XOR of all data bytes (length bytes excluded). Match -> DONE; mismatch -> ERR.
  - N == 0 still expects a checksum byte of 8'h00.
  - All words have already been written by the time the checksum is checked.
- Not defined: no CSUM state; the last WRITE goes directly to DONE.

Test Plan:
- Reset, then start_i, then bytes 02 00 00 00, 13 05 A0 00, 93 05 B0 00 at full rate -> two write pulses:
  - addr 0x0 with 0x00A00513.
  - addr 0x4 with 0x00B00593.
  - done_o = 1 and core_rst_o = 0 on the cycle after the second write.
- Length bytes 01 04 00 00 (N = 1025) -> error_o = 1, no mem_we_o pulse, core_rst_o stays 1.
- Length 00 00 00 00 -> done_o = 1 with zero writes; with LOADER_CHECKSUM_EN, needs byte 00 first.
- Random byte_valid_i gaps of 0-7 cycles with N = 3 -> identical writes and addresses to the gap-free run; byte_ready_o = 0 during each WRITE cycle.
- rst_i asserted after 2 data bytes of word 1, then deasserted -> IDLE with all outputs at reset values. A following start_i plus a full image loads correctly from BASE_ADDR.
- LOADER_CHECKSUM_EN with N = 1 word 0x00A00513:
  - Checksum byte B6 -> done_o = 1.
  - Checksum byte B7 -> error_o = 1, and the word is still written at addr 0x0.
